// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result serializer: FSM encoding, byte size
// and the fixed unit priority used by the capture mux.
package alu_pkg;

  localparam int BYTE = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Enum order is the priority order: the lowest value wins a collision.
  typedef enum logic [1:0] {
    UNIT_ARITH = 2'd0,
    UNIT_LOGIC = 2'd1,
    UNIT_CMP   = 2'd2,
    UNIT_SHIFT = 2'd3
  } unit_t;

  // flags[0] = arith, flags[1] = logic, flags[2] = cmp, flags[3] = shift.
  function automatic unit_t pick_unit(input logic [3:0] flags);
    unit_t winner;
    winner = UNIT_SHIFT;
    for (int i = 3; i >= 0; i--) begin
      if (flags[i]) winner = unit_t'(2'(i));
    end
    return winner;
  endfunction

  function automatic logic multi_hot(input logic [3:0] flags);
    return (flags & (flags - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous FIFO buffering captured result words; a push into a full FIFO
// is accepted only when a pop frees the head slot in the same cycle.
module alu_res_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is left unreset; count/pointers gate every read, so stale
  // contents are never observable and the array can map to plain registers/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Captures ALU unit results by fixed priority into a FIFO and streams each
// word out LSB-first as bytes over a valid/ready interface.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0] logic_out,
  input  logic [WIDTH-1:0] cmp_out,
  input  logic [WIDTH-1:0] shift_out,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             overflow,
  output logic             collision
);

  localparam int NB    = WIDTH / BYTE;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t             state, next_state;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         flags;
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH-1:0]   head;
  logic [BYTE-1:0]    head_bytes [NB];
  logic               full, empty;
  logic [CNT_W-1:0]   count;
  logic               handshake, last_byte, pop, push_req, push_ok;

  assign flags     = {shift_flag, cmp_flag, logic_flag, arith_flag};
  assign handshake = (state == SEND) && tx_ready;
  assign last_byte = (idx == IDX_W'(NB - 1));
  assign pop       = handshake && last_byte;
  assign push_req  = (|flags) && !rst;
  assign push_ok   = push_req && (!full || pop);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_data = shift_out;
    case (pick_unit(flags))
      UNIT_ARITH: sel_data = arith_out;
      UNIT_LOGIC: sel_data = logic_out;
      UNIT_CMP:   sel_data = cmp_out;
      UNIT_SHIFT: sel_data = shift_out;
      default:    sel_data = shift_out;
    endcase
  end

  alu_res_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (sel_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Leaving IDLE on the capturing edge gives byte 0 the cycle after the flag.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (push_ok || !empty) next_state = SEND;
      SEND:    if (pop && count == CNT_W'(1) && !push_ok) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      state <= next_state;
      if (handshake) idx <= last_byte ? '0 : idx + 1'b1;
      if (push_req && !push_ok) overflow <= 1'b1;
      if (multi_hot(flags)) collision <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NB; i++) head_bytes[i] = head[i*BYTE +: BYTE];
  end

  always_comb begin
    tx_data = '0;
    if (state == SEND) tx_data = head_bytes[idx];
  end

  assign tx_valid = (state == SEND);
  assign busy     = (state == SEND) || (count != '0);

endmodule

// File: tb/tb_alu_result_serializer.sv
// Scoreboard bench: stimulus pushes expected bytes, a negedge monitor pops
// and compares on every accepted handshake.
module tb_alu_result_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] arith_out, logic_out, cmp_out, shift_out;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overflow;
  logic        collision;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  alu_result_serializer #(.WIDTH(16), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .arith_out  (arith_out),
    .logic_out  (logic_out),
    .cmp_out    (cmp_out),
    .shift_out  (shift_out),
    .arith_flag (arith_flag),
    .logic_flag (logic_flag),
    .cmp_flag   (cmp_flag),
    .shift_flag (shift_flag),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .overflow   (overflow),
    .collision  (collision)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: inputs change #1 after posedge, so negedge sees the handshake
  // that the next posedge will take.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("tx_byte", {24'd0, tx_data}, {24'd0, e});
      end
    end
  end

  initial begin
    rst = 1'b1;
    {arith_out, logic_out, cmp_out, shift_out} = '0;
    {arith_flag, logic_flag, cmp_flag, shift_flag} = '0;
    tx_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_collision", {31'd0, collision}, 32'd0);

    // Single word, ready high: 5A in N+1, A5 in N+2, idle in N+3.
    tx_ready = 1'b1;
    shift_out = 16'hA55A; shift_flag = 1'b1; push_word(16'hA55A);
    step();
    shift_flag = 1'b0;
    check("single_b0_valid", {31'd0, tx_valid}, 32'd1);
    check("single_b0_data", {24'd0, tx_data}, 32'h5A);
    step();
    check("single_b1_data", {24'd0, tx_data}, 32'hA5);
    step();
    check("single_end_valid", {31'd0, tx_valid}, 32'd0);
    check("single_end_busy", {31'd0, busy}, 32'd0);

    // Backpressure: byte 0 held stable for 5 cycles.
    tx_ready = 1'b0;
    arith_out = 16'h1234; arith_flag = 1'b1; push_word(16'h1234);
    step();
    arith_flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, tx_valid}, 32'd1);
      check("bp_data", {24'd0, tx_data}, 32'h34);
      step();
    end
    tx_ready = 1'b1;
    wait_idle();

    // Full-plus-pop: push lands in the cycle the head's final byte goes.
    tx_ready = 1'b0;
    logic_out = 16'hA1A2; logic_flag = 1'b1; push_word(16'hA1A2);
    step();
    logic_out = 16'hB1B2; push_word(16'hB1B2);
    step();
    logic_flag = 1'b0; tx_ready = 1'b1;
    check("fpp_full_valid", {31'd0, tx_valid}, 32'd1);
    step();
    logic_out = 16'hC1C2; logic_flag = 1'b1; push_word(16'hC1C2);
    check("fpp_last_byte", {24'd0, tx_data}, 32'hA1);
    step();
    logic_flag = 1'b0;
    check("fpp_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("fpp_no_gap", {31'd0, tx_valid}, 32'd1);
      step();
    end
    check("fpp_done", {31'd0, tx_valid}, 32'd0);
    check("fpp_overflow_end", {31'd0, overflow}, 32'd0);

    // Collision: arith wins over cmp.
    arith_out = 16'h0001; cmp_out = 16'h0002;
    arith_flag = 1'b1; cmp_flag = 1'b1; push_word(16'h0001);
    step();
    arith_flag = 1'b0; cmp_flag = 1'b0;
    check("coll_flag", {31'd0, collision}, 32'd1);
    wait_idle();
    check("coll_sticky", {31'd0, collision}, 32'd1);

    // Overflow: third word dropped while stalled.
    tx_ready = 1'b0;
    logic_flag = 1'b1;
    logic_out = 16'h1111; push_word(16'h1111);
    step();
    logic_out = 16'h2222; push_word(16'h2222);
    step();
    logic_out = 16'h3333;
    step();
    logic_flag = 1'b0;
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    tx_ready = 1'b1;
    wait_idle();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-word: EF accepted, BE must never appear.
    arith_out = 16'hBEEF; arith_flag = 1'b1; exp_q.push_back(8'hEF);
    step();
    arith_flag = 1'b0;
    check("mid_b0_data", {24'd0, tx_data}, 32'hEF);
    step();
    rst = 1'b1; tx_ready = 1'b0;
    step();
    rst = 1'b0;
    check("mid_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_overflow", {31'd0, overflow}, 32'd0);
    check("mid_collision", {31'd0, collision}, 32'd0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("mid_quiet", {31'd0, tx_valid}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
